// File: rtl/async_fifo_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_pkg
// Shared definitions for the read- and write-side controllers of the
// asynchronous FIFO:
//   - default address/data widths
//   - output-buffer state encoding
//   - Gray/binary pointer conversion helpers
// The converters work on a fixed 32-bit container. Callers zero-extend
// narrower pointers into it and keep only the low bits of the result.
// Zero-extension leaves the low bits of both conversions unchanged.
// -----------------------------------------------------------------------------
package async_fifo_pkg;

  localparam int DEF_ADDRESS_WIDTH = 7;
  localparam int DEF_DATA_WIDTH    = 16;

  localparam int PTR_MAX_W = 32;
  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Encoding equals the number of buffered words, so count can be the state.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } skid_state_e;

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// -----------------------------------------------------------------------------
// fifo_out_skid
// Two-entry output buffer between the RAM read port and the output stream.
// Words arrive through push, one cycle after the RAM read strobe. Words leave
// through pop. dout always shows the oldest buffered word.
//
// Ports
//   CLK_RD  in   read-domain clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   push    in   din holds a word to store this cycle
//   pop     in   the word on dout is taken this cycle
//   din     in   incoming word (RAM read data)
//   valid   out  at least one word buffered (registered)
//   dout    out  oldest buffered word (registered)
//   count   out  number of buffered words, 0..2
//
// state | meaning
// ------+--------------------------------------------
// B0    | empty, valid low
// B1    | one word, held in dout
// B2    | two words, oldest in dout, newer in slot1
//
// The caller never pushes into B2 without a pop in the same cycle.
// -----------------------------------------------------------------------------
module fifo_out_skid
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  CLK_RD,
  input  logic                  RST_N,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  skid_state_e           state;
  logic [DATA_WIDTH-1:0] slot1;

  always_ff @(posedge CLK_RD or negedge RST_N) begin
    if (!RST_N) begin
      state <= B0;
      valid <= 1'b0;
      dout  <= '0;
      slot1 <= '0;
    end else begin
      case (state)
        B0: begin
          if (push) begin
            state <= B1;
            valid <= 1'b1;
            dout  <= din;
          end
        end
        B1: begin
          if (push && pop) begin
            dout <= din;
          end else if (push) begin
            state <= B2;
            slot1 <= din;
          end else if (pop) begin
            state <= B0;
            valid <= 1'b0;
          end
        end
        B2: begin
          if (pop) begin
            dout <= slot1;
            if (push) begin
              slot1 <= din;
            end else begin
              state <= B1;
            end
          end
        end
        default: begin
          state <= B0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign count = state;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller of an asynchronous FIFO. It does four things:
//   - compares the synchronized write pointer with the read pointer;
//   - issues RAM reads to keep the two-entry output buffer full;
//   - presents the buffered words as a valid/ready stream;
//   - exports the read pointer in Gray code to the write domain.
//
// Ports
//   CLK_RD            in   read-domain clock, rising edge
//   RST_N             in   asynchronous active-low reset
//   WR_PTR_GRAY_SYNC  in   write pointer, Gray, already synchronized
//   RD_PTR_GRAY       out  read pointer, Gray, registered
//   RAM_RD_EN         out  RAM read strobe
//   RAM_ADDR_RD       out  RAM read address
//   RAM_Q             in   RAM read data, valid the cycle after RAM_RD_EN
//   M_VALID/M_READY   out/in  output stream handshake
//   M_DATA            out  oldest buffered word
//   EMPTY             out  nothing stored, in flight or buffered
//   RD_LEVEL          out  readable word count
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     CLK_RD,
  input  logic                     RST_N,
  input  logic [ADDRESS_WIDTH:0]   WR_PTR_GRAY_SYNC,
  output logic [ADDRESS_WIDTH:0]   RD_PTR_GRAY,
  output logic                     RAM_RD_EN,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADDR_RD,
  input  logic [DATA_WIDTH-1:0]    RAM_Q,
  output logic                     M_VALID,
  input  logic                     M_READY,
  output logic [DATA_WIDTH-1:0]    M_DATA,
  output logic                     EMPTY,
  output logic [ADDRESS_WIDTH+1:0] RD_LEVEL
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam int LW = ADDRESS_WIDTH + 2;

  logic [PW-1:0] rd_ptr_gray_q;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_nxt;
  logic [PW-1:0] rd_gray_nxt;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] ram_words;

  // High bits of the 32-bit conversion container, always zero here.
  logic [PTR_MAX_W-PW-1:0] unused_wr_hi;
  logic [PTR_MAX_W-PW-1:0] unused_rd_hi;
  logic [PTR_MAX_W-PW-1:0] unused_nxt_hi;

  logic       inflight;
  logic       rd_active;
  logic       ram_empty;
  logic       rd_en;
  logic       push;
  logic       pop;
  logic [1:0] count;
  logic [2:0] occupancy;

  assign {unused_wr_hi, wr_bin}       = gray2bin(ptr_max_t'(WR_PTR_GRAY_SYNC));
  assign {unused_rd_hi, rd_bin}       = gray2bin(ptr_max_t'(rd_ptr_gray_q));
  assign rd_bin_nxt                   = rd_bin + PW'(1);
  assign {unused_nxt_hi, rd_gray_nxt} = bin2gray(ptr_max_t'(rd_bin_nxt));

  assign ram_empty = (wr_bin == rd_bin);
  assign ram_words = wr_bin - rd_bin;

  assign pop  = M_VALID && M_READY;
  assign push = inflight;

  // Buffer words after this cycle, ignoring the read we may issue now.
  // The result never exceeds 2, so a read never overfills the buffer.
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);

  // rd_active is low in reset and until the first edge after release.
  // This keeps the strobe quiet while the pointers are still settling.
  assign rd_en = rd_active && !ram_empty && (occupancy < 3'd2);

  always_ff @(posedge CLK_RD or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_gray_q <= '0;
      inflight      <= 1'b0;
      rd_active     <= 1'b0;
    end else begin
      rd_active <= 1'b1;
      inflight  <= rd_en;
      if (rd_en) begin
        rd_ptr_gray_q <= rd_gray_nxt;
      end
    end
  end

  fifo_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .CLK_RD (CLK_RD),
    .RST_N  (RST_N),
    .push   (push),
    .pop    (pop),
    .din    (RAM_Q),
    .valid  (M_VALID),
    .dout   (M_DATA),
    .count  (count)
  );

  assign RAM_RD_EN   = rd_en;
  assign RAM_ADDR_RD = rd_bin[ADDRESS_WIDTH-1:0];
  assign RD_PTR_GRAY = rd_ptr_gray_q;

  // Status reads as idle during reset, even if the write pointer is nonzero.
  assign EMPTY    = !rd_active || (ram_empty && !inflight && (count == 2'd0));
  assign RD_LEVEL = rd_active ? (LW'(ram_words) + LW'(inflight) + LW'(count)) : '0;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          CLK_RD = 1'b0;
  logic          RST_N  = 1'b0;
  logic [PW-1:0] WR_PTR_GRAY_SYNC = '0;
  logic [PW-1:0] RD_PTR_GRAY;
  logic          RAM_RD_EN;
  logic [AW-1:0] RAM_ADDR_RD;
  logic [DW-1:0] RAM_Q = '0;
  logic          M_VALID;
  logic          M_READY = 1'b0;
  logic [DW-1:0] M_DATA;
  logic          EMPTY;
  logic [AW+1:0] RD_LEVEL;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rd_issue = 0;

  fifo_rd_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK_RD           (CLK_RD),
    .RST_N            (RST_N),
    .WR_PTR_GRAY_SYNC (WR_PTR_GRAY_SYNC),
    .RD_PTR_GRAY      (RD_PTR_GRAY),
    .RAM_RD_EN        (RAM_RD_EN),
    .RAM_ADDR_RD      (RAM_ADDR_RD),
    .RAM_Q            (RAM_Q),
    .M_VALID          (M_VALID),
    .M_READY          (M_READY),
    .M_DATA           (M_DATA),
    .EMPTY            (EMPTY),
    .RD_LEVEL         (RD_LEVEL)
  );

  always #5 CLK_RD = ~CLK_RD;

  always @(posedge CLK_RD) if (RAM_RD_EN) RAM_Q <= mem[RAM_ADDR_RD];

  function automatic logic [DW-1:0] data_of(input int n);
    int v;
    v = n * 40503 + 7;
    return v[DW-1:0];
  endfunction

  function automatic logic [PW-1:0] gray_of(input int n);
    logic [PW-1:0] b;
    b = n[PW-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic write_word();
    mem[AW'(wr_cnt % DEPTH)] = data_of(wr_cnt);
    wr_cnt++;
    WR_PTR_GRAY_SYNC = gray_of(wr_cnt);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    M_READY = 1'b0;
    WR_PTR_GRAY_SYNC = gray_of(5);
    repeat (2) @(negedge CLK_RD);
    #1;
    checks++; if (RAM_RD_EN !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", RAM_RD_EN); end
    checks++; if (M_VALID !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", M_VALID); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", EMPTY); end
    checks++; if (RD_LEVEL !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", RD_LEVEL); end
    checks++; if (RD_PTR_GRAY !== '0) begin errors++; $display("FAIL reset_rd_gray: got %h want 0", RD_PTR_GRAY); end
    checks++; if (M_DATA !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", M_DATA); end
    checks++; if (RAM_ADDR_RD !== '0) begin errors++; $display("FAIL reset_addr: got %0d want 0", RAM_ADDR_RD); end
    WR_PTR_GRAY_SYNC = '0;
    @(negedge CLK_RD);
    RST_N = 1'b1;
    #1;
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL release_empty: got %b want 1", EMPTY); end
    wr_cnt = 0; rd_cnt = 0; rd_issue = 0;
    repeat (2) @(negedge CLK_RD);
  endtask

  task automatic test_basic();
    int first_en = -1;
    int last_en = -1;
    int first_valid = -1;
    M_READY = 1'b1;
    @(negedge CLK_RD);
    for (int k = 0; k < 3; k++) write_word();
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge CLK_RD);
      #1;
      if (RAM_RD_EN) begin
        checks++; if (RAM_ADDR_RD !== AW'(rd_issue)) begin errors++; $display("FAIL basic_addr: got %0d want %0d", RAM_ADDR_RD, rd_issue); end
        if (first_en < 0) first_en = cyc;
        else begin
          checks++; if (cyc != last_en + 1) begin errors++; $display("FAIL basic_consecutive: read at cycle %0d want %0d", cyc, last_en + 1); end
        end
        last_en = cyc;
        rd_issue++;
      end
      if (M_VALID && first_valid < 0) first_valid = cyc;
      if (M_VALID && M_READY) begin
        checks++; if (M_DATA !== data_of(rd_cnt)) begin errors++; $display("FAIL basic_data: got %h want %h", M_DATA, data_of(rd_cnt)); end
        rd_cnt++;
      end
    end
    checks++; if (rd_issue != 3) begin errors++; $display("FAIL basic_reads: got %0d want 3", rd_issue); end
    checks++; if (first_valid - first_en != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", first_valid - first_en); end
    checks++; if (rd_cnt != 3) begin errors++; $display("FAIL basic_pops: got %0d want 3", rd_cnt); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", EMPTY); end
  endtask

  task automatic test_backpressure();
    int n_en = 0;
    bit done = 0;
    M_READY = 1'b0;
    @(negedge CLK_RD);
    for (int k = 0; k < 5; k++) write_word();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc > 0) @(negedge CLK_RD);
      #1;
      if (RAM_RD_EN) begin
        checks++; if (RAM_ADDR_RD !== AW'(rd_issue)) begin errors++; $display("FAIL bp_addr: got %0d want %0d", RAM_ADDR_RD, rd_issue); end
        rd_issue++; n_en++;
      end
    end
    checks++; if (n_en != 2) begin errors++; $display("FAIL bp_reads: got %0d want 2", n_en); end
    checks++; if (dut.u_skid.count !== 2'd2) begin errors++; $display("FAIL bp_state: got %0d want 2", dut.u_skid.count); end
    checks++; if (RD_LEVEL !== 9'd5) begin errors++; $display("FAIL bp_level: got %0d want 5", RD_LEVEL); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge CLK_RD); #1;
      checks++; if (M_VALID !== 1'b1 || M_DATA !== data_of(rd_cnt)) begin errors++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", M_VALID, M_DATA, data_of(rd_cnt)); end
      checks++; if (RAM_RD_EN !== 1'b0) begin errors++; $display("FAIL bp_extra_read: got %b want 0", RAM_RD_EN); end
    end
    @(negedge CLK_RD);
    M_READY = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge CLK_RD);
      #1;
      if (RAM_RD_EN) begin
        checks++; if (RAM_ADDR_RD !== AW'(rd_issue)) begin errors++; $display("FAIL bp_drain_addr: got %0d want %0d", RAM_ADDR_RD, rd_issue); end
        rd_issue++;
      end
      if (M_VALID && M_READY) begin
        checks++; if (M_DATA !== data_of(rd_cnt)) begin errors++; $display("FAIL bp_drain_data: got %h want %h", M_DATA, data_of(rd_cnt)); end
        rd_cnt++;
      end
      done = EMPTY;
    end
    checks++; if (rd_cnt != 8 || EMPTY !== 1'b1) begin errors++; $display("FAIL bp_drain: got pops=%0d empty=%b want 8 and 1", rd_cnt, EMPTY); end
  endtask

  task automatic test_wrap();
    bit done = 0;
    bit saw_wrap = 0;
    int last_addr = -1;
    logic [PW-1:0] prev_gray;
    M_READY = 1'b1;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge CLK_RD);
      if (wr_cnt < 253 && wr_cnt - rd_cnt < 64) write_word();
      #1;
      if (RAM_RD_EN) begin
        checks++; if (RAM_ADDR_RD !== AW'(rd_issue)) begin errors++; $display("FAIL wrap_pre_addr: got %0d want %0d", RAM_ADDR_RD, rd_issue); end
        rd_issue++;
      end
      if (M_VALID && M_READY) begin
        checks++; if (M_DATA !== data_of(rd_cnt)) begin errors++; $display("FAIL wrap_pre_data: got %h want %h", M_DATA, data_of(rd_cnt)); end
        rd_cnt++;
      end
      done = (wr_cnt == 253) && EMPTY;
    end
    checks++; if (rd_cnt != 253) begin errors++; $display("FAIL wrap_preset: got %0d want 253", rd_cnt); end
    @(negedge CLK_RD);
    #1;
    prev_gray = RD_PTR_GRAY;
    checks++; if (prev_gray !== gray_of(253)) begin errors++; $display("FAIL wrap_start_gray: got %h want %h", prev_gray, gray_of(253)); end
    @(negedge CLK_RD);
    for (int k = 0; k < 7; k++) write_word();
    done = 0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      if (cyc > 0) @(negedge CLK_RD);
      #1;
      checks++; if (RD_PTR_GRAY !== gray_of(rd_issue)) begin errors++; $display("FAIL wrap_gray: got %h want %h", RD_PTR_GRAY, gray_of(rd_issue)); end
      checks++; if ($countones(RD_PTR_GRAY ^ prev_gray) > 1) begin errors++; $display("FAIL wrap_gray_step: got %h after %h want one bit change", RD_PTR_GRAY, prev_gray); end
      prev_gray = RD_PTR_GRAY;
      if (RAM_RD_EN) begin
        checks++; if (RAM_ADDR_RD !== AW'(rd_issue)) begin errors++; $display("FAIL wrap_addr: got %0d want %0d", RAM_ADDR_RD, rd_issue % DEPTH); end
        if (last_addr == DEPTH - 1 && RAM_ADDR_RD == '0) saw_wrap = 1;
        last_addr = int'(RAM_ADDR_RD);
        rd_issue++;
      end
      if (M_VALID && M_READY) begin
        checks++; if (M_DATA !== data_of(rd_cnt)) begin errors++; $display("FAIL wrap_data: got %h want %h", M_DATA, data_of(rd_cnt)); end
        rd_cnt++;
      end
      done = (rd_cnt == 260) && EMPTY;
    end
    checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_addr_127_to_0: got no wrap want 127 then 0"); end
    checks++; if (rd_cnt != 260 || RD_PTR_GRAY !== gray_of(260)) begin errors++; $display("FAIL wrap_end: got pops=%0d gray=%h want 260 and %h", rd_cnt, RD_PTR_GRAY, gray_of(260)); end
  endtask

  task automatic test_random();
    int target;
    bit held = 0;
    target = wr_cnt + 1000;
    for (int cyc = 0; cyc < 8000 && rd_cnt < target; cyc++) begin
      @(negedge CLK_RD);
      M_READY = 1'($urandom_range(0, 1));
      if (wr_cnt < target && wr_cnt - rd_cnt < 100 && $urandom_range(0, 3) != 0) write_word();
      #1;
      if (held) begin
        checks++; if (M_VALID !== 1'b1) begin errors++; $display("FAIL rnd_valid_drop: got %b want 1", M_VALID); end
      end
      if (RAM_RD_EN) begin
        checks++; if (rd_issue == wr_cnt) begin errors++; $display("FAIL rnd_read_empty: got read with %0d words want none", wr_cnt - rd_issue); end
        checks++; if (RAM_ADDR_RD !== AW'(rd_issue)) begin errors++; $display("FAIL rnd_addr: got %0d want %0d", RAM_ADDR_RD, rd_issue % DEPTH); end
        rd_issue++;
      end
      if (M_VALID) begin
        checks++; if (M_DATA !== data_of(rd_cnt)) begin errors++; $display("FAIL rnd_data: got %h want %h (word %0d)", M_DATA, data_of(rd_cnt), rd_cnt); end
        if (M_READY) rd_cnt++;
      end
      held = M_VALID && !M_READY;
    end
    M_READY = 1'b1;
    repeat (4) @(negedge CLK_RD);
    #1;
    checks++; if (rd_cnt != target || EMPTY !== 1'b1) begin errors++; $display("FAIL rnd_complete: got pops=%0d empty=%b want %0d and 1", rd_cnt, EMPTY, target); end
  endtask

  task automatic test_reset_inflight();
    bit done = 0;
    M_READY = 1'b1;
    @(negedge CLK_RD);
    write_word();
    #1;
    checks++; if (RAM_RD_EN !== 1'b1) begin errors++; $display("FAIL rst_pre_read: got %b want 1", RAM_RD_EN); end
    @(negedge CLK_RD);
    RST_N = 1'b0;
    #1;
    checks++; if (M_VALID !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", M_VALID); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %b want 1", EMPTY); end
    checks++; if (RAM_RD_EN !== 1'b0) begin errors++; $display("FAIL rst_async_rd_en: got %b want 0", RAM_RD_EN); end
    checks++; if (RD_PTR_GRAY !== '0 || RD_LEVEL !== '0) begin errors++; $display("FAIL rst_async_ptr: got gray=%h level=%0d want 0 and 0", RD_PTR_GRAY, RD_LEVEL); end
    @(negedge CLK_RD);
    #1;
    checks++; if (M_VALID !== 1'b0 || M_DATA !== '0) begin errors++; $display("FAIL rst_dropped: got v=%b d=%h want 0 and 0", M_VALID, M_DATA); end
    wr_cnt = 0; rd_cnt = 0; rd_issue = 0;
    write_word();
    write_word();
    @(negedge CLK_RD);
    RST_N = 1'b1;
    #1;
    checks++; if (RAM_RD_EN !== 1'b0) begin errors++; $display("FAIL rst_release_rd_en: got %b want 0", RAM_RD_EN); end
    for (int cyc = 0; cyc < 15 && !done; cyc++) begin
      @(negedge CLK_RD); #1;
      if (RAM_RD_EN) begin
        checks++; if (RAM_ADDR_RD !== AW'(rd_issue)) begin errors++; $display("FAIL rst_after_addr: got %0d want %0d", RAM_ADDR_RD, rd_issue); end
        rd_issue++;
      end
      if (M_VALID && M_READY) begin
        checks++; if (M_DATA !== data_of(rd_cnt)) begin errors++; $display("FAIL rst_after_data: got %h want %h", M_DATA, data_of(rd_cnt)); end
        rd_cnt++;
      end
      done = (rd_cnt == 2) && EMPTY;
    end
    checks++; if (rd_cnt != 2 || rd_issue != 2 || EMPTY !== 1'b1) begin errors++; $display("FAIL rst_after_count: got pops=%0d reads=%0d empty=%b want 2 2 1", rd_cnt, rd_issue, EMPTY); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_random();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 7, SHALL set the RAM read address width; pointers are ADDRESS_WIDTH+1 bits.
REQ-002 Parameter DATA_WIDTH, default 16, SHALL set the read data width, equal to the RAM read port width.
REQ-003 The block SHALL use one clock, CLK_RD (input, 1); all logic is on its rising edge.
REQ-004 RST_N (input, 1) SHALL be the reset: asynchronous, active-low.
REQ-005 WR_PTR_GRAY_SYNC (input, ADDRESS_WIDTH+1) SHALL carry the write pointer in Gray code, already synchronized into CLK_RD.
REQ-006 RD_PTR_GRAY (output, ADDRESS_WIDTH+1) SHALL carry the registered read pointer in Gray code, for export to the write domain.
REQ-007 RAM_RD_EN (output, 1) SHALL be the RAM read strobe.
REQ-008 RAM_ADDR_RD (output, ADDRESS_WIDTH) SHALL be the RAM read address.
REQ-009 RAM_Q (input, DATA_WIDTH) SHALL be RAM read data, valid the cycle after RAM_RD_EN.
REQ-010 M_VALID (output, 1), M_READY (input, 1) and M_DATA (output, DATA_WIDTH) SHALL form the output stream handshake.
REQ-011 EMPTY (output, 1) SHALL flag that no word is stored, in flight or buffered.
REQ-012 RD_LEVEL (output, ADDRESS_WIDTH+2) SHALL report the readable word count.

Function
REQ-013 wr_bin/rd_bin SHALL be Gray-to-binary conversions of WR_PTR_GRAY_SYNC and the internal read pointer; ram_empty = (wr_bin == rd_bin).
REQ-014 A 2-entry output buffer SHALL be controlled by states B0 (0 words), B1 (1 word), B2 (2 words); M_VALID = (state != B0).
REQ-015 pop = M_VALID && M_READY; push = the registered RAM_RD_EN from the previous cycle (inflight).
REQ-016 Transitions: B0->B1 on push; B1->B0 on pop without push; B1->B2 on push without pop; B2->B1 on pop; push with pop SHALL keep the state.
REQ-017 RAM_RD_EN SHALL be asserted combinationally when !ram_empty && (count + inflight - pop) < 2, with count = 0/1/2 for B0/B1/B2.
REQ-018 RAM_ADDR_RD SHALL equal rd_bin[ADDRESS_WIDTH-1:0].
REQ-019 Each issued read SHALL increment the read pointer modulo 2^(ADDRESS_WIDTH+1).
REQ-020 RD_PTR_GRAY SHALL equal bin2gray(rd_bin) registered, so exactly one bit changes per increment, including the wrap from all-ones to 0.
REQ-021 Latency: a word visible through WR_PTR_GRAY_SYNC in cycle t (with the buffer empty) SHALL give RAM_RD_EN in t, RAM_Q capture at the end of t+1, and M_VALID in t+2.
REQ-022 M_DATA SHALL always present the oldest buffered word; M_DATA and M_VALID SHALL stay stable while M_VALID && !M_READY.
REQ-023 Words SHALL leave in strict write order, with no drop or duplication.
REQ-024 M_READY held high with data continuously available SHALL sustain one word per cycle.
REQ-025 EMPTY SHALL be high when ram_empty && !inflight && state == B0.
REQ-026 RD_LEVEL SHALL equal (wr_bin - rd_bin mod 2^(ADDRESS_WIDTH+1)) + inflight + count, computed in ADDRESS_WIDTH+2 bits.
REQ-027 The block SHALL not detect write-side overflow; the write side guarantees it.

Reset
REQ-028 While RST_N is low: read pointer = 0, RD_PTR_GRAY = 0, inflight = 0, state = B0, M_VALID = 0, M_DATA = 0, RAM_RD_EN = 0, EMPTY = 1, RD_LEVEL = 0.
REQ-029 Reset asserted with a read in flight SHALL discard that word; after release, only WR_PTR_GRAY_SYNC relative to 0 determines available data.
REQ-030 After RST_N deasserts, the first RAM_RD_EN SHALL occur no earlier than the first rising CLK_RD edge.

Structure
REQ-031 Package async_fifo_pkg SHALL hold the bin2gray/gray2bin functions and the default ADDRESS_WIDTH/DATA_WIDTH constants, shared with the write-side controller.
REQ-032 The 2-entry output buffer SHALL be the sub-module fifo_out_skid, parameterized by DATA_WIDTH, with push/pop/count ports; all pointer logic stays in fifo_rd_ctrl.

Verification
REQ-033 Reset, then set WR_PTR_GRAY_SYNC to gray(3) with M_READY=1 -> RAM_ADDR_RD 0,1,2 on consecutive cycles; M_DATA = RAM contents in order; M_VALID first high 2 cycles after the first RAM_RD_EN; EMPTY returns to 1.
REQ-034 Load 5 words with M_READY=0 -> exactly 2 RAM reads; state B2; RD_LEVEL = 5; M_DATA holds word 0 stable until M_READY rises.
REQ-035 ADDRESS_WIDTH=7, pointer preset near wrap (255 -> 0) -> RD_PTR_GRAY changes one bit per step; RAM_ADDR_RD goes 127 -> 0; data remains in order.
REQ-036 Random M_READY toggling, 1000 words -> a scoreboard shows no loss, duplication or reordering; RAM_RD_EN is never asserted while ram_empty.
REQ-037 Assert RST_N low in the cycle after RAM_RD_EN -> the in-flight word is dropped; M_VALID = 0 and EMPTY = 1 immediately (asynchronously).
